// File: rtl/owen_sample_scheduler.sv
// Frame sequencer ahead of the Owen scrambler: credit-metered issue of one beat per sample.
// Optional stall counters are enabled by defining OWEN_SCHED_STATS_EN.
module owen_sample_scheduler #(
  parameter int DIMS       = 2,
  parameter int FRAC_BITS  = 32,
  parameter int INDEX_BITS = 32,
  parameter int SPP_BITS   = 16,
  parameter int CREDITS    = 16
) (
  input  logic                      s00_axis_aclk,
  input  logic                      s00_axis_aresetn,
  input  logic [FRAC_BITS-1:0]      cfg_num_pixels,
  input  logic [SPP_BITS-1:0]       cfg_spp,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      s00_axis_tvalid,
  input  logic [DIMS*FRAC_BITS-1:0] s00_axis_tdata,
  output logic                      s00_axis_tready,
  output logic                      m00_axis_tvalid,
  input  logic                      m00_axis_tready,
  output logic [DIMS*FRAC_BITS-1:0] m00_axis_tdata,
  output logic                      m00_axis_tlast,
  output logic [FRAC_BITS-1:0]      pixel_id,
  output logic [FRAC_BITS-1:0]      sample_id,
  output logic [INDEX_BITS-1:0]     sample_index,
  input  logic                      credit_return,
  output logic                      credit_err
`ifdef OWEN_SCHED_STATS_EN
  ,
  output logic [31:0]               stat_stall_credit,
  output logic [31:0]               stat_stall_input
`endif
);

  localparam int DW = DIMS*FRAC_BITS;
  localparam int CW = $clog2(CREDITS+1);
  localparam logic [CW-1:0] C_FULL = CW'(CREDITS);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [DW-1:0]         data;
    logic [FRAC_BITS-1:0]  pixel;
    logic [SPP_BITS-1:0]   sample;
    logic [INDEX_BITS-1:0] index;
    logic                  last;
  } beat_t;

  wire clk   = s00_axis_aclk;
  wire rst_n = s00_axis_aresetn;

  state_t                r_state;
  logic [CW-1:0]         r_credits;
  logic                  r_credit_err;
  logic                  r_busy;
  logic                  r_done;
  logic [FRAC_BITS-1:0]  r_num_pix;
  logic [SPP_BITS-1:0]   r_spp;
  logic [FRAC_BITS-1:0]  r_pix_cnt;
  logic [SPP_BITS-1:0]   r_smp_cnt;
  logic [INDEX_BITS-1:0] r_idx_cnt;
  logic                  r_m_tvalid;
  beat_t                 r_beat;

  logic w_credit_avail;
  logic w_out_free;
  logic w_ready;
  logic w_accept;
  logic w_smp_last;
  logic w_pix_last;

  // A same-cycle credit return covers an issue even when the counter reads zero.
  assign w_credit_avail = (r_credits != '0) || credit_return;
  assign w_out_free     = !r_m_tvalid || m00_axis_tready;
  assign w_ready        = (r_state == S_RUN) && w_credit_avail && w_out_free;
  assign w_accept       = w_ready && s00_axis_tvalid;
  assign w_smp_last     = (r_smp_cnt == r_spp - SPP_BITS'(1));
  assign w_pix_last     = (r_pix_cnt == r_num_pix - FRAC_BITS'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credits    <= C_FULL;
      r_credit_err <= 1'b0;
    end else begin
      unique case ({w_accept, credit_return})
        2'b10: r_credits <= r_credits - C_ONE;
        2'b01: begin
          if (r_credits == C_FULL) r_credit_err <= 1'b1;
          else                     r_credits    <= r_credits + C_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_num_pix <= '0;
      r_spp     <= '0;
      r_pix_cnt <= '0;
      r_smp_cnt <= '0;
      r_idx_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_pix <= cfg_num_pixels;
            r_spp     <= cfg_spp;
            r_pix_cnt <= '0;
            r_smp_cnt <= '0;
            r_idx_cnt <= '0;
            if (cfg_num_pixels == '0 || cfg_spp == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_idx_cnt <= r_idx_cnt + INDEX_BITS'(1);
            if (w_smp_last) begin
              r_smp_cnt <= '0;
              r_pix_cnt <= r_pix_cnt + FRAC_BITS'(1);
              if (w_pix_last) r_state <= S_DRAIN;
            end else begin
              r_smp_cnt <= r_smp_cnt + SPP_BITS'(1);
            end
          end
        end
        S_DRAIN: begin
          if (r_credits == C_FULL) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sideband is captured with the point so it stays aligned under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_tvalid <= 1'b0;
      r_beat     <= '0;
    end else if (w_accept) begin
      r_m_tvalid    <= 1'b1;
      r_beat.data   <= s00_axis_tdata;
      r_beat.pixel  <= r_pix_cnt;
      r_beat.sample <= r_smp_cnt;
      r_beat.index  <= r_idx_cnt;
      r_beat.last   <= w_smp_last;
    end else if (m00_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

`ifdef OWEN_SCHED_STATS_EN
  logic [31:0] r_stall_credit;
  logic [31:0] r_stall_input;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_credit <= '0;
      r_stall_input  <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_stall_credit <= '0;
      r_stall_input  <= '0;
    end else if (r_state == S_RUN) begin
      if (!w_credit_avail) begin
        if (r_stall_credit != '1) r_stall_credit <= r_stall_credit + 32'd1;
      end else if (!s00_axis_tvalid) begin
        if (r_stall_input != '1) r_stall_input <= r_stall_input + 32'd1;
      end
    end
  end

  assign stat_stall_credit = r_stall_credit;
  assign stat_stall_input  = r_stall_input;
`endif

  assign s00_axis_tready = w_ready;
  assign m00_axis_tvalid = r_m_tvalid;
  assign m00_axis_tdata  = r_beat.data;
  assign m00_axis_tlast  = r_beat.last;
  assign pixel_id        = r_beat.pixel;
  assign sample_id       = FRAC_BITS'(r_beat.sample);
  assign sample_index    = r_beat.index;
  assign busy            = r_busy;
  assign done            = r_done;
  assign credit_err      = r_credit_err;

endmodule
